// File: rtl/uart_tx_peripheral_if.sv
// Register bus between the data memory mapper and the UART transmitter.
// The mapper drives the decode strobes and store data, and the peripheral
// returns combinational read data for the mapper's read-data mux.
interface uart_tx_peripheral_if;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [63:0] wdata;
    logic [63:0] rdata;

    modport master (
        output sel,
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  sel,
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter.
// Stores to TXDATA fill a circular byte FIFO; a baud-timed FSM pops bytes and
// shifts them out LSB first on a registered txd line. STATUS and BAUDDIV are
// readable through the combinational rdata path.
module uart_tx_peripheral #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 868
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_peripheral_if.slave  bus,
    output logic                 txd
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             overflow_reg;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    // Control registers
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_reload;

    // Serialiser state
    state_t           state_reg;
    state_t           state_next;
    logic [2:0]       idx_reg;
    logic [2:0]       idx_next;
    logic [DIV_W-1:0] baud_reg;
    logic [DIV_W-1:0] baud_next;
    logic [7:0]       shift_reg;
    logic             txd_reg;
    logic             txd_next;
    logic             bit_end;

    // Decoded bus strobes
    logic             wr_txdata;
    logic             wr_status;
    logic             wr_baud;
    logic [63:0]      rdata_next;
    logic             unused_wdata;

    assign wr_txdata  = bus.sel & bus.we & (bus.addr == 2'd0);
    assign wr_status  = bus.sel & bus.we & (bus.addr == 2'd1);
    assign wr_baud    = bus.sel & bus.we & (bus.addr == 2'd2);

    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    // A push into a full FIFO is dropped even if a pop frees a slot this edge.
    assign push       = wr_txdata & ~fifo_full;

    assign bit_end    = (baud_reg == '0);
    // Each bit lasts div_reg cycles: counter runs div_reg-1 down to 0.
    assign div_reload = div_reg - DIV_W'(1);

    // Only the low byte / low DIV_W bits of store data are meaningful.
    assign unused_wdata = ^bus.wdata;

    // FIFO storage write; no reset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= bus.wdata[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Registered FIFO read: popped byte lands in the shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
        end else if (pop) begin
            shift_reg <= fifo_mem[rd_ptr_reg];
        end
    end

    // Sticky overflow flag and baud divisor register
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
            div_reg      <= DIV_W'(DEFAULT_DIV);
        end else begin
            if (wr_txdata && fifo_full) begin
                overflow_reg <= 1'b1;
            end else if (wr_status && bus.wdata[3]) begin
                overflow_reg <= 1'b0;
            end
            if (wr_baud) begin
                div_reg <= (bus.wdata[DIV_W-1:0] == '0) ? DIV_W'(1)
                                                        : bus.wdata[DIV_W-1:0];
            end
        end
    end

    // Serialiser state register; txd is a flop so the line never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            baud_reg  <= '0;
            txd_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            baud_reg  <= baud_next;
            txd_reg   <= txd_next;
        end
    end

    // Serialiser next state: txd_next is the line level for the coming cycle
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        baud_next  = baud_reg;
        txd_next   = txd_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                txd_next  = 1'b1;
                baud_next = '0;
                idx_next  = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                    txd_next   = 1'b0;
                    baud_next  = div_reload;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    idx_next   = '0;
                    txd_next   = shift_reg[0];
                    baud_next  = div_reload;
                end else begin
                    baud_next = baud_reg - DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next = div_reload;
                    if (idx_reg == 3'd7) begin
                        state_next = STOP;
                        txd_next   = 1'b1;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                        txd_next = shift_reg[idx_reg + 3'd1];
                    end
                end else begin
                    baud_next = baud_reg - DIV_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next frame with no idle gap.
                        pop        = 1'b1;
                        state_next = START;
                        txd_next   = 1'b0;
                        baud_next  = div_reload;
                    end else begin
                        state_next = IDLE;
                        txd_next   = 1'b1;
                        baud_next  = '0;
                        idx_next   = '0;
                    end
                end else begin
                    baud_next = baud_reg - DIV_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

    // Register read mux; returns 0 when not selected
    always_comb begin
        rdata_next = '0;
        if (bus.sel) begin
            case (bus.addr)
                2'd1: begin
                    rdata_next[0]    = fifo_full;
                    rdata_next[1]    = fifo_empty;
                    rdata_next[2]    = (state_reg != IDLE);
                    rdata_next[3]    = overflow_reg;
                    rdata_next[15:8] = 8'(count_reg);
                end
                2'd2: begin
                    rdata_next[DIV_W-1:0] = div_reg;
                end
                default: begin
                    rdata_next = '0;
                end
            endcase
        end
    end

    assign bus.rdata = rdata_next;
    assign txd       = txd_reg;

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Testbench for uart_tx_peripheral. Stimulus pushes each accepted byte (with
// the bit period it should use) into a scoreboard queue; a monitor watching
// txd decodes every frame it sees, pops the queue and compares the whole
// waveform against an ideal 8N1 frame.
module tb_uart_tx_peripheral;
    logic clk = 1'b0;
    logic rst;
    logic txd;

    uart_tx_peripheral_if bus_if();

    uart_tx_peripheral #(
        .FIFO_DEPTH (16),
        .DIV_W      (16),
        .DEFAULT_DIV(868)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave),
        .txd (txd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    frame_t exp_q[$];
    int     start_q[$];
    int     vectors     = 0;
    int     miscompares = 0;
    int     cyc         = 0;
    int     div_model   = 868;

    always @(posedge clk) cyc++;

    // ---------------- monitor ----------------
    logic       mon_busy = 1'b0;
    logic       mon_ok;
    logic       mon_known;
    frame_t     mon_cur;
    logic [7:0] mon_rx;
    int         mon_pos;
    int         mon_bit;
    logic       mon_exp;

    always @(negedge clk) begin
        if (rst) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (txd !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    mon_known = 1'b0;
                    mon_cur.data = 8'h00;
                    mon_cur.div  = div_model;
                end else begin
                    mon_known = 1'b1;
                    mon_cur = exp_q.pop_front();
                end
                start_q.push_back(cyc);
                mon_ok   = mon_known && (txd === 1'b0);
                mon_rx   = 8'h00;
                mon_pos  = 1;
                mon_busy = 1'b1;
            end
        end else begin
            mon_bit = mon_pos / mon_cur.div;
            if (mon_bit == 0)      mon_exp = 1'b0;
            else if (mon_bit == 9) mon_exp = 1'b1;
            else                   mon_exp = mon_cur.data[mon_bit-1];
            if (mon_bit >= 1 && mon_bit <= 8 && (mon_pos % mon_cur.div) == mon_cur.div / 2)
                mon_rx[mon_bit-1] = txd;
            if (txd !== mon_exp) mon_ok = 1'b0;
            mon_pos++;
            if (mon_pos == 10 * mon_cur.div) begin
                mon_busy = 1'b0;
                vectors++;
                if (!mon_ok) begin
                    miscompares++;
                    if (mon_known)
                        $display("FAIL frame: got byte 0x%02h (waveform off), required byte 0x%02h with %0d cycles/bit, start cycle %0d",
                                 mon_rx, mon_cur.data, mon_cur.div, start_q[start_q.size()-1]);
                    else
                        $display("FAIL frame: got unexpected frame byte 0x%02h at cycle %0d, required idle line (nothing queued)",
                                 mon_rx, start_q[start_q.size()-1]);
                end else begin
                    $display("frame ok: byte 0x%02h div %0d", mon_cur.data, mon_cur.div);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end else begin
            $display("ok %s: 0x%0h", name, act);
        end
    endtask

    function automatic logic [63:0] st(input bit full, input bit empty, input bit busy,
                                       input bit ovf, input int count);
        logic [63:0] v;
        v = '0;
        v[0] = full;
        v[1] = empty;
        v[2] = busy;
        v[3] = ovf;
        v[15:8] = 8'(count);
        return v;
    endfunction

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        @(negedge clk);
        bus_if.sel   = 1'b1;
        bus_if.we    = 1'b1;
        bus_if.addr  = a;
        bus_if.wdata = d;
    endtask

    task automatic rd(input logic [1:0] a, output logic [63:0] d);
        @(negedge clk);
        bus_if.sel  = 1'b1;
        bus_if.we   = 1'b0;
        bus_if.addr = a;
        #1 d = bus_if.rdata;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus_if.sel = 1'b0;
        bus_if.we  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Store a byte with random junk in the ignored upper bits; it will be sent.
    task automatic send(input logic [7:0] b);
        logic [63:0] d;
        d = {$urandom, $urandom};
        d[7:0] = b;
        wr(2'd0, d);
        exp_q.push_back('{data: b, div: div_model});
    endtask

    task automatic setdiv(input int d);
        wr(2'd2, 64'(d));
        div_model = (d == 0) ? 1 : d;
    endtask

    // Poll STATUS until idle and empty, bounded by a cycle budget.
    task automatic drain(input string name, input int budget);
        logic [63:0] s;
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            rd(2'd1, s);
            if (s[2] == 1'b0 && s[1] == 1'b1) done = 1;
        end
        idle(0);
        check({name, "_drained"}, 64'(done), 64'd1);
        check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] r;
        int n;

        rst = 1'b1;
        bus_if.sel = 1'b0;
        bus_if.we = 1'b0;
        bus_if.addr = 2'd0;
        bus_if.wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset_txd", 64'(txd), 64'd1);
        rd(2'd1, r); check("reset_status", r, st(0, 1, 0, 0, 0));
        rd(2'd2, r); check("reset_bauddiv", r, 64'd868);
        rd(2'd3, r); check("reset_reserved", r, 64'd0);
        rd(2'd0, r); check("read_txdata", r, 64'd0);

        // Single 0xA5 frame at 4 cycles/bit, with pop latency check
        setdiv(4);
        rd(2'd2, r); check("bauddiv_4", r, 64'd4);
        send(8'hA5);
        idle(0);
        check("latency_before_pop", 64'(txd), 64'd1);
        @(negedge clk);
        check("latency_start_bit", 64'(txd), 64'd0);
        rd(2'd1, r); check("busy_midframe", r, st(0, 1, 1, 0, 0));
        idle(0);
        drain("a5", 100);

        // Three back-to-back bytes at 2 cycles/bit: no gap between frames
        setdiv(2);
        start_q.delete();
        send(8'h3C); send(8'hFF); send(8'h00);
        idle(42);
        rd(2'd1, r); check("b2b_empty_after_third_pop", r, st(0, 1, 1, 0, 0));
        idle(0);
        drain("b2b", 100);
        check("b2b_frames", 64'(start_q.size()), 64'd3);
        if (start_q.size() == 3) begin
            check("b2b_gap1", 64'(start_q[1] - start_q[0]), 64'd20);
            check("b2b_gap2", 64'(start_q[2] - start_q[1]), 64'd20);
        end

        // Divisor 0 stores 1: ten-cycle frames
        setdiv(0);
        rd(2'd2, r); check("bauddiv_zero_reads_1", r, 64'd1);
        send(8'($urandom));
        idle(0);
        drain("div1", 50);

        // Randomised bursts at random divisors and random write spacing
        for (int k = 0; k < 4; k++) begin
            setdiv($urandom_range(1, 6));
            n = $urandom_range(2, 6);
            for (int j = 0; j < n; j++) begin
                send(8'($urandom));
                if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 30));
            end
            idle(0);
            drain("random", 1000);
        end

        // Fill the FIFO behind a stalled transmitter, then overflow it
        setdiv(16'hFFFF);
        for (int j = 0; j < 17; j++) send(8'($urandom));
        rd(2'd1, r); check("fill_full", r, st(1, 0, 1, 0, 16));
        wr(2'd0, 64'h0000_0000_0000_00EE);
        rd(2'd1, r); check("overflow_set", r, st(1, 0, 1, 1, 16));
        wr(2'd1, 64'h7);
        rd(2'd1, r); check("overflow_kept_bit3_0", r, st(1, 0, 1, 1, 16));
        wr(2'd1, 64'h8);
        rd(2'd1, r); check("overflow_cleared", r, st(1, 0, 1, 0, 16));
        @(negedge clk);
        bus_if.sel = 1'b0; bus_if.we = 1'b1; bus_if.addr = 2'd0; bus_if.wdata = 64'h55;
        #1 check("rdata_unselected", bus_if.rdata, 64'd0);
        rd(2'd1, r); check("unselected_no_push", r, st(1, 0, 1, 0, 16));
        idle(0);

        // Reset aborts everything
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        div_model = 868;
        rd(2'd1, r); check("rst_status_after_fill", r, st(0, 1, 0, 0, 0));
        idle(0);

        // Reset in the middle of the data bits
        setdiv(4);
        send(8'($urandom));
        idle(16);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_txd", 64'(txd), 64'd1);
        rd(2'd1, r); check("midrst_status", r, st(0, 1, 0, 0, 0));
        rd(2'd2, r); check("midrst_bauddiv", r, 64'd868);
        idle(0);
        rst = 1'b0;
        div_model = 868;
        idle(2);
        check("midrst_txd_idle", 64'(txd), 64'd1);

        // Recovery after reset
        setdiv(3);
        send(8'h81);
        idle(0);
        drain("recover", 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

endmodule
